// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with shared period, prescaler and edge/center counting.
// Duty, period and mode are double-buffered and load only on a period boundary.
module pwm_multichannel #(
   parameter int unsigned NUM_CH  = 16,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned PRESC_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en_out,
   input  logic [NUM_CH-1:0]       en_pwm,
   input  logic [NUM_CH*CNT_W-1:0] duty,
   input  logic [CNT_W-1:0]        period,
   input  logic [PRESC_W-1:0]      prescale,
   input  logic                    center_mode,
   input  logic                    update,
   output logic [NUM_CH-1:0]       out,
   output logic                    period_tick
);

   logic [PRESC_W-1:0]      presc_q, presc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_nat;
   logic                    dir_dn_q, dir_dn_d, dir_nat;
   logic                    pending_q, pending_d;
   logic [NUM_CH*CNT_W-1:0] duty_act_q, duty_sh_q;
   logic [CNT_W-1:0]        period_act_q, period_sh_q;
   logic                    mode_act_q, mode_sh_q;
   logic [NUM_CH-1:0]       out_d;
   logic                    tick, boundary, load;

   always_comb begin
      // >= keeps the prescaler from running away when prescale shrinks below the count
      tick    = (presc_q >= prescale);
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);

      cnt_nat = '0;
      dir_nat = 1'b0;
      if (!mode_act_q) begin
         cnt_nat = (cnt_q >= period_act_q) ? '0 : cnt_q + CNT_W'(1);
      end else if (!dir_dn_q && (cnt_q < period_act_q)) begin
         cnt_nat = cnt_q + CNT_W'(1);
      end else if (cnt_q <= CNT_W'(1)) begin
         cnt_nat = '0;
      end else begin
         cnt_nat = cnt_q - CNT_W'(1);
         dir_nat = 1'b1;
      end

      boundary = tick && (cnt_nat == '0);
      load     = boundary && pending_q;

      cnt_d    = tick ? cnt_nat : cnt_q;
      dir_dn_d = tick ? dir_nat : dir_dn_q;
      if (load) begin
         cnt_d    = '0;
         dir_dn_d = 1'b0;
      end

      pending_d = pending_q;
      if (load) pending_d = 1'b0;
      if (update) pending_d = 1'b1;

      out_d = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         out_d[i] = en_out[i] & (~en_pwm[i] | (cnt_q < duty_act_q[i*CNT_W +: CNT_W]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= '0;
         cnt_q        <= '0;
         dir_dn_q     <= 1'b0;
         pending_q    <= 1'b0;
         duty_act_q   <= '0;
         duty_sh_q    <= '0;
         period_act_q <= '1;
         period_sh_q  <= '1;
         mode_act_q   <= 1'b0;
         mode_sh_q    <= 1'b0;
         out          <= '0;
         period_tick  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         cnt_q       <= cnt_d;
         dir_dn_q    <= dir_dn_d;
         pending_q   <= pending_d;
         out         <= out_d;
         period_tick <= boundary;
         if (load) begin
            duty_act_q   <= duty_sh_q;
            period_act_q <= period_sh_q;
            mode_act_q   <= mode_sh_q;
         end
         if (update) begin
            duty_sh_q   <= duty;
            period_sh_q <= period;
            mode_sh_q   <= center_mode;
         end
      end
   end

endmodule
